mem_march_ctrl: RTL and testbench
=================================

MEM_MARCH_CTRL -- requirements
Module: mem_march_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, memory address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 8, memory word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request to run one March C- pass; sampled on clk.
REQ-006 SHALL have port mem_we  output  1  memory write enable; the memory writes on the next rising edge.
REQ-007 SHALL have port mem_addr  output  ADDR_W  memory address for read and write.
REQ-008 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-009 SHALL have port mem_rdata  input  DATA_W  memory read data, combinational from mem_addr in the same cycle.
REQ-010 SHALL have port busy  output  1  high while the test runs.
REQ-011 SHALL have port done  output  1  high from test completion until the next accepted start.
REQ-012 SHALL have port fail  output  1  sticky: at least one read miscompare in this pass.
REQ-013 SHALL have port fail_addr  output  ADDR_W  address of the first miscompare.
REQ-014 SHALL have port fail_elem  output  3  March element index (0-5) of the first miscompare.
REQ-015 SHALL have port err_count  output  8  number of miscompares, saturating at 255.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE; IDLE->RUN or DONE->RUN on start=1 at a clock edge; start in RUN SHALL be ignored.
REQ-017 SHALL, on accepting start, clear fail, fail_addr, fail_elem and err_count in the same edge, and set element=0, addr=0.
REQ-018 SHALL execute one memory operation per cycle in RUN, in these elements: E0 up w0; E1 up r0,w1; E2 up r1,w0; E3 down r0,w1; E4 down r1,w0; E5 down r0. Up order = 0..31, down order = 31..0. 0 = all-zeros word, 1 = all-ones word.
REQ-019 SHALL, for multi-op elements, perform the read then the write at the same address on consecutive cycles before advancing the address.
REQ-020 SHALL drive write cycles as mem_we=1, mem_addr=current address, mem_wdata=pattern.
REQ-021 SHALL drive read cycles as mem_we=0, mem_addr=current address, mem_wdata=0, and compare mem_rdata to the expected pattern in that cycle.
REQ-022 SHALL, on a miscompare, increment err_count at that edge (hold at 255). If fail was 0, it SHALL also set fail=1 and capture fail_addr/fail_elem.
REQ-023 SHALL complete a pass in exactly 320 RUN cycles: E0 32, E1-E4 64 each, E5 32.
REQ-024 SHALL go RUN->DONE at the edge ending the E5 address-0 read; in DONE, done=1 and busy=0.
REQ-025 SHALL hold busy=1 for exactly the 320 RUN cycles; busy and done SHALL never both be 1.
REQ-026 SHALL, in IDLE and DONE, drive mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-027 SHALL hold fail, fail_addr, fail_elem and err_count stable in DONE until the next accepted start.
REQ-028 SHALL treat address wrap as element termination: the address counter SHALL never wrap within an element.

Reset
REQ-029 SHALL, on rst_n=0 at any time including mid-RUN, immediately enter IDLE, stop any write in progress, and drive every output to 0.
REQ-030 SHALL leave memory contents undefined after a mid-run reset; a new start SHALL rerun from E0.

Verification
REQ-031 SHALL cover a fault-free 32x8 model, start pulse: cycles 1-32 show mem_we=1, addr 0..31, wdata 0x00; cycle 33 shows mem_we=0, addr 0. Done after 320 cycles with fail=0 and err_count=0.
REQ-032 SHALL cover bit 3 at address 7 stuck at 0: expected fail=1, fail_addr=7, fail_elem=2, err_count=2.
REQ-033 SHALL cover all bits at address 0 stuck at 1: expected fail=1, fail_addr=0, fail_elem=1, err_count=3.
REQ-034 SHALL cover start re-pulsed at RUN cycle 100: it SHALL be ignored and done SHALL still occur at cycle 320.
REQ-035 SHALL cover rst_n low at RUN cycle 150: outputs are 0 at once; a later start gives a full 320-cycle pass.
REQ-036 SHALL cover a second start from DONE after a failing pass against a good model: flags clear at acceptance and finish with fail=0.

Source files
------------

// File: rtl/mem_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_march_ctrl
// Purpose  : March C- memory test sequencer. It runs one pass over a
//            single-port memory with combinational read data, and it records
//            the first failing address and element plus a saturating
//            miscompare count.
// Revision : 1.0 - initial release
// ============================================================================
module mem_march_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [7:0]        err_count
);

  localparam logic [1:0]        C_ST_IDLE   = 2'd0;
  localparam logic [1:0]        C_ST_RUN    = 2'd1;
  localparam logic [1:0]        C_ST_DONE   = 2'd2;
  localparam logic [2:0]        C_ELEM_LAST = 3'd5;
  localparam logic [ADDR_W-1:0] C_ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] C_ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] C_ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] C_ONES      = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] C_ZEROS     = {DATA_W{1'b0}};

  logic [1:0]        state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;   // 0 = read slot, 1 = write slot
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [7:0]        err_count_q, err_count_d;

  // Decode of the current element: direction, which ops it has, and its data patterns.
  logic              w_run, w_up, w_has_read, w_has_write, w_two_op;
  logic              w_is_read, w_is_write, w_op_last, w_addr_last;
  logic              w_accept, w_miscmp;
  logic [DATA_W-1:0] w_rd_pat, w_wr_pat;

  assign w_run       = (state_q == C_ST_RUN);
  assign w_up        = (elem_q <= 3'd2);
  assign w_has_read  = (elem_q != 3'd0);
  assign w_has_write = (elem_q != C_ELEM_LAST);
  assign w_two_op    = w_has_read && w_has_write;
  assign w_is_read   = w_run && w_has_read && !phase_q;
  assign w_is_write  = w_run && w_has_write && (!w_has_read || phase_q);
  assign w_op_last   = !w_two_op || phase_q;
  assign w_addr_last = w_up ? (addr_q == C_ADDR_MAX) : (addr_q == C_ADDR_ZERO);
  assign w_rd_pat    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? C_ONES : C_ZEROS;
  assign w_wr_pat    = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? C_ONES : C_ZEROS;
  assign w_accept    = ((state_q == C_ST_IDLE) || (state_q == C_ST_DONE)) && start;

  // State and datapath registers; reset parks everything in IDLE with zeroed results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= C_ST_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= C_ADDR_ZERO;
      phase_q     <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= C_ADDR_ZERO;
      fail_elem_q <= 3'd0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state sequencing: read slot, then write slot, then advance address; element ends at the address boundary.
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    case (state_q)
      C_ST_IDLE, C_ST_DONE: begin
        if (start) begin
          state_d = C_ST_RUN;
          elem_d  = 3'd0;
          addr_d  = C_ADDR_ZERO;
          phase_d = 1'b0;
        end
      end
      C_ST_RUN: begin
        if (!w_op_last) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (w_addr_last) begin
            if (elem_q == C_ELEM_LAST) begin
              state_d = C_ST_DONE;
              elem_d  = 3'd0;
              addr_d  = C_ADDR_ZERO;
            end else begin
              elem_d = elem_q + 3'd1;
              // Elements 0..2 ascend and 3..5 descend, so the seed depends on the element being entered.
              addr_d = (elem_q < 3'd2) ? C_ADDR_ZERO : C_ADDR_MAX;
            end
          end else begin
            addr_d = w_up ? (addr_q + C_ADDR_ONE) : (addr_q - C_ADDR_ONE);
          end
        end
      end
      default: begin
        state_d = C_ST_IDLE;
        elem_d  = 3'd0;
        addr_d  = C_ADDR_ZERO;
        phase_d = 1'b0;
      end
    endcase
  end

  // Result tracking: clear on an accepted start, otherwise log miscompares and keep only the first location.
  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    err_count_d = err_count_q;
    if (w_accept) begin
      fail_d      = 1'b0;
      fail_addr_d = C_ADDR_ZERO;
      fail_elem_d = 3'd0;
      err_count_d = 8'd0;
    end else if (w_miscmp) begin
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = addr_q;
        fail_elem_d = elem_q;
      end
    end
  end

  // Output decode: memory bus idles at zero outside RUN, and read data is checked in the read slot.
  always_comb begin
    mem_we    = w_is_write;
    mem_addr  = w_run ? addr_q : C_ADDR_ZERO;
    mem_wdata = w_is_write ? w_wr_pat : C_ZEROS;
    busy      = w_run;
    done      = (state_q == C_ST_DONE);
    w_miscmp  = w_is_read && (mem_rdata != w_rd_pat);
  end

  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_march_ctrl
// Purpose  : Self-checking bench for mem_march_ctrl. A 32x8 memory model with
//            optional stuck-at fault is attached. The expected bus operations
//            and the final results are queued when start is driven, and they
//            are popped as the DUT runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_march_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int WORDS  = 32;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } op_t;

  typedef struct packed {
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic [7:0]        err_count;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy, done, fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [7:0]        err_count;

  logic [DATA_W-1:0] mem [WORDS];
  logic              flt_en = 1'b0;
  logic [ADDR_W-1:0] flt_addr = '0;
  logic [DATA_W-1:0] flt_and = 8'hFF;
  logic [DATA_W-1:0] flt_or = 8'h00;

  op_t  op_q[$];
  res_t res_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  mem_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read with an optional stuck-at overlay.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign mem_rdata = (flt_en && (mem_addr == flt_addr)) ?
                     ((mem[mem_addr] & flt_and) | flt_or) : mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference March C- operation list, written out element by element.
  task automatic push_ops();
    op_t o;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < WORDS; i++) begin
        o.addr = (e < 3) ? ADDR_W'(i) : ADDR_W'(WORDS - 1 - i);
        if (e != 0) begin
          o.we = 1'b0; o.wdata = 8'h00;
          op_q.push_back(o);
        end
        if (e != 5) begin
          o.we = 1'b1;
          o.wdata = ((e == 1) || (e == 3)) ? 8'hFF : 8'h00;
          op_q.push_back(o);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},     {31'd0, mem_we},    32'd0);
    check({tag, "_addr"},   {27'd0, mem_addr},  32'd0);
    check({tag, "_wdata"},  {24'd0, mem_wdata}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy},      32'd0);
    check({tag, "_done"},   {31'd0, done},      32'd0);
    check({tag, "_fail"},   {31'd0, fail},      32'd0);
    check({tag, "_faddr"},  {27'd0, fail_addr}, 32'd0);
    check({tag, "_felem"},  {29'd0, fail_elem}, 32'd0);
    check({tag, "_errcnt"}, {24'd0, err_count}, 32'd0);
  endtask

  // One pass: queue expectations, pulse start, follow all 320 RUN cycles, then check the outcome.
  task automatic run_pass(input string name, input int repulse_at, input int reset_at, input res_t exp);
    op_t  o;
    res_t r;
    op_q.delete();
    push_ops();
    res_q.push_back(exp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_acc_fail"},   {31'd0, fail},      32'd0);
    check({name, "_acc_errcnt"}, {24'd0, err_count}, 32'd0);
    check({name, "_acc_done"},   {31'd0, done},      32'd0);
    for (int c = 1; c <= 320; c++) begin
      o = op_q.pop_front();
      check($sformatf("%s_c%0d_we", name, c),    {31'd0, mem_we},    {31'd0, o.we});
      check($sformatf("%s_c%0d_addr", name, c),  {27'd0, mem_addr},  {27'd0, o.addr});
      check($sformatf("%s_c%0d_wdata", name, c), {24'd0, mem_wdata}, {24'd0, o.wdata});
      check($sformatf("%s_c%0d_busy", name, c),  {30'd0, busy, done}, 32'd2);
      if (c == repulse_at) start = 1'b1;
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero({name, "_midrst"});
        op_q.delete();
        res_q.delete();
        #1;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    r = res_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_end%0d_done", name, k),   {30'd0, busy, done},  32'd1);
      check($sformatf("%s_end%0d_we", name, k),     {31'd0, mem_we},      32'd0);
      check($sformatf("%s_end%0d_addr", name, k),   {27'd0, mem_addr},    32'd0);
      check($sformatf("%s_end%0d_fail", name, k),   {31'd0, fail},        {31'd0, r.fail});
      check($sformatf("%s_end%0d_faddr", name, k),  {27'd0, fail_addr},   {27'd0, r.fail_addr});
      check($sformatf("%s_end%0d_felem", name, k),  {29'd0, fail_elem},   {29'd0, r.fail_elem});
      check($sformatf("%s_end%0d_errcnt", name, k), {24'd0, err_count},   {24'd0, r.err_count});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle");

    // Fault-free pass.
    run_pass("good", 0, 0, '{fail: 1'b0, fail_addr: 5'd0, fail_elem: 3'd0, err_count: 8'd0});

    // Bit 3 of address 7 stuck at 0: caught by the r1 reads of E2 and E4.
    flt_en = 1'b1; flt_addr = 5'd7; flt_and = 8'hF7; flt_or = 8'h00;
    run_pass("sa0", 0, 0, '{fail: 1'b1, fail_addr: 5'd7, fail_elem: 3'd2, err_count: 8'd2});

    // Address 0 stuck at all ones: caught by the r0 reads of E1, E3 and E5.
    flt_en = 1'b1; flt_addr = 5'd0; flt_and = 8'hFF; flt_or = 8'hFF;
    run_pass("sa1", 0, 0, '{fail: 1'b1, fail_addr: 5'd0, fail_elem: 3'd1, err_count: 8'd3});

    // Restart from DONE after a failing pass with the fault removed.
    flt_en = 1'b0;
    run_pass("rerun", 0, 0, '{fail: 1'b0, fail_addr: 5'd0, fail_elem: 3'd0, err_count: 8'd0});

    // Start re-pulsed mid-run is ignored.
    run_pass("repulse", 100, 0, '{fail: 1'b0, fail_addr: 5'd0, fail_elem: 3'd0, err_count: 8'd0});

    // Reset mid-run, then a complete fresh pass.
    run_pass("rstmid", 0, 150, '{fail: 1'b0, fail_addr: 5'd0, fail_elem: 3'd0, err_count: 8'd0});
    @(posedge clk); #1;
    check_all_zero("postrst");
    run_pass("afterrst", 0, 0, '{fail: 1'b0, fail_addr: 5'd0, fail_elem: 3'd0, err_count: 8'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
